// File: rtl/commit_trace_fifo_if.sv
// Trace drain channel of commit_trace_fifo: head entry plus valid/ready handshake.
// The FIFO drives it through the master modport; the host uses the slave modport.
interface commit_trace_fifo_if;
    logic        trace_valid;
    logic        trace_ready;
    logic        trace_kind;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [3:0]  trace_byteen;
    logic [31:0] trace_data;

    modport master (
        output trace_valid, trace_kind, trace_pc, trace_addr, trace_byteen, trace_data,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_kind, trace_pc, trace_addr, trace_byteen, trace_data,
        output trace_ready
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// Program-order FIFO of GRF writes and DM stores with sticky overflow and saturating drop count.
// Define TRACE_DM_EN to build DM store capture and the second write port.
module commit_trace_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       w_grf_we,
    input  logic [4:0]                 w_grf_addr,
    input  logic [31:0]                w_grf_wdata,
    input  logic [31:0]                w_inst_addr,
    input  logic [3:0]                 m_data_byteen,
    input  logic [31:0]                m_data_addr,
    input  logic [31:0]                m_data_wdata,
    input  logic [31:0]                m_inst_addr,
    commit_trace_fifo_if.master        trace,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;
    logic [31:0]       r_pc_mem   [DEPTH];
    logic [31:0]       r_addr_mem [DEPTH];
    logic [31:0]       r_data_mem [DEPTH];
`ifdef TRACE_DM_EN
    logic              r_kind_mem [DEPTH];
    logic [3:0]        r_be_mem   [DEPTH];
    logic [AW-1:0]     w_dm_idx;
`else
    logic              w_unused_dm;
    assign w_unused_dm = ^{m_data_byteen, m_data_addr, m_data_wdata, m_inst_addr};
`endif

    logic              w_valid;
    logic              w_pop;
    logic [LW:0]       w_free;
    logic              w_grf_cand;
    logic              w_grf_push;
    logic              w_dm_cand;
    logic              w_dm_push;
    logic [1:0]        w_n_push;
    logic [1:0]        w_n_drop;
    logic [DROP_W:0]   w_drop_sum;

    always_comb begin
        w_valid    = (r_level != '0);
        w_pop      = w_valid & trace.trace_ready & ~clear;
        // A same-cycle pop frees the head slot for this cycle's push.
        w_free     = (LW+1)'(DEPTH) - {1'b0, r_level} + (LW+1)'(w_pop);
        w_grf_cand = w_grf_we & (w_grf_addr != 5'd0) & ~clear;
        w_grf_push = w_grf_cand & (w_free != '0);
`ifdef TRACE_DM_EN
        w_dm_cand  = (m_data_byteen != 4'b0000) & ~clear;
        w_dm_push  = w_dm_cand & (w_free > (LW+1)'(w_grf_push));
        w_dm_idx   = w_grf_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
`else
        w_dm_cand  = 1'b0;
        w_dm_push  = 1'b0;
`endif
        w_n_push   = {1'b0, w_grf_push} + {1'b0, w_dm_push};
        w_n_drop   = {1'b0, w_grf_cand & ~w_grf_push} + {1'b0, w_dm_cand & ~w_dm_push};
        w_drop_sum = {1'b0, r_drop_count} + (DROP_W+1)'(w_n_drop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_level  <= r_level + LW'(w_n_push) - LW'(w_pop);
            if (w_n_drop != 2'd0) begin
                r_overflow <= 1'b1;
            end
            r_drop_count <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
        end
    end

    // Payload storage needs no reset: the head is masked by w_valid.
    always_ff @(posedge clk) begin
        if (w_grf_push) begin
            r_pc_mem[r_wr_ptr]   <= w_inst_addr;
            r_addr_mem[r_wr_ptr] <= {27'b0, w_grf_addr};
            r_data_mem[r_wr_ptr] <= w_grf_wdata;
`ifdef TRACE_DM_EN
            r_kind_mem[r_wr_ptr] <= 1'b0;
            r_be_mem[r_wr_ptr]   <= 4'b1111;
`endif
        end
`ifdef TRACE_DM_EN
        if (w_dm_push) begin
            r_pc_mem[w_dm_idx]   <= m_inst_addr;
            r_addr_mem[w_dm_idx] <= {m_data_addr[31:2], 2'b00};
            r_data_mem[w_dm_idx] <= m_data_wdata;
            r_kind_mem[w_dm_idx] <= 1'b1;
            r_be_mem[w_dm_idx]   <= m_data_byteen;
        end
`endif
    end

    always_comb begin
        trace.trace_valid = w_valid;
        trace.trace_pc    = w_valid ? r_pc_mem[r_rd_ptr]   : 32'd0;
        trace.trace_addr  = w_valid ? r_addr_mem[r_rd_ptr] : 32'd0;
        trace.trace_data  = w_valid ? r_data_mem[r_rd_ptr] : 32'd0;
`ifdef TRACE_DM_EN
        trace.trace_kind   = w_valid & r_kind_mem[r_rd_ptr];
        trace.trace_byteen = w_valid ? r_be_mem[r_rd_ptr] : 4'b0000;
`else
        trace.trace_kind   = 1'b0;
        trace.trace_byteen = 4'b1111;
`endif
        level      = r_level;
        overflow   = r_overflow;
        drop_count = r_drop_count;
    end
endmodule
